// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with a valid/ready stream interface.
// Subnormals flush to zero and rounding is round-to-nearest-even.
module fp_mul_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic [3:0]   flags
);

  localparam int EW2  = EXP_W + 2;
  localparam int PW   = 2 * MAN_W + 2;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX = (1 << EXP_W) - 1;

  localparam logic [EW2-1:0] BIAS_E = EW2'(BIAS);
  localparam logic [EW2-1:0] EMAX_E = EW2'(EMAX);
  localparam logic [W-1:0]   QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // Stage handshake: each stage moves when it is empty or its successor moves.
  logic s1_v, s2_v;
  logic s1_rdy, s2_rdy, s3_rdy;

  assign s3_rdy   = !out_valid || out_ready;
  assign s2_rdy   = !s2_v || s3_rdy;
  assign s1_rdy   = !s1_v || s2_rdy;
  assign in_ready = s1_rdy;

  // ---------------- S1: unpack and classify ----------------
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_zero, a_inf, a_nan;
  logic             b_zero, b_inf, b_nan;
  logic             nan_d, inf_d, zero_d;
  logic [EW2-1:0]   exp_d;

  assign sa = a[W-1];
  assign sb = b[W-1];
  assign ea = a[W-2:MAN_W];
  assign eb = b[W-2:MAN_W];
  assign fa = a[MAN_W-1:0];
  assign fb = b[MAN_W-1:0];

  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == '1) && (fa == '0);
  assign b_inf  = (eb == '1) && (fb == '0);
  assign a_nan  = (ea == '1) && (fa != '0);
  assign b_nan  = (eb == '1) && (fb != '0);

  assign nan_d  = a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero);
  assign inf_d  = a_inf || b_inf;
  assign zero_d = a_zero || b_zero;
  // Two extra bits keep the biased sum and its negative excursions in range.
  assign exp_d  = {2'b00, ea} + {2'b00, eb} - BIAS_E;

  logic             s1_sign, s1_nan, s1_inf, s1_zero;
  logic [EW2-1:0]   s1_exp;
  logic [MAN_W:0]   s1_ma, s1_mb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_sign <= 1'b0;
      s1_nan  <= 1'b0;
      s1_inf  <= 1'b0;
      s1_zero <= 1'b0;
      s1_exp  <= '0;
      s1_ma   <= '0;
      s1_mb   <= '0;
    end else if (s1_rdy) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_sign <= sa ^ sb;
        s1_nan  <= nan_d;
        s1_inf  <= inf_d;
        s1_zero <= zero_d;
        s1_exp  <= exp_d;
        s1_ma   <= {1'b1, fa};
        s1_mb   <= {1'b1, fb};
      end
    end
  end

  // ---------------- S2: mantissa multiply ----------------
  logic [PW-1:0] prod_d;

  assign prod_d = {{(MAN_W+1){1'b0}}, s1_ma} * {{(MAN_W+1){1'b0}}, s1_mb};

  logic           s2_sign, s2_nan, s2_inf, s2_zero;
  logic [EW2-1:0] s2_exp;
  logic [PW-1:0]  s2_prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v    <= 1'b0;
      s2_sign <= 1'b0;
      s2_nan  <= 1'b0;
      s2_inf  <= 1'b0;
      s2_zero <= 1'b0;
      s2_exp  <= '0;
      s2_prod <= '0;
    end else if (s2_rdy) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_sign <= s1_sign;
        s2_nan  <= s1_nan;
        s2_inf  <= s1_inf;
        s2_zero <= s1_zero;
        s2_exp  <= s1_exp;
        s2_prod <= prod_d;
      end
    end
  end

  // ---------------- S3: normalise, round, pack ----------------
  logic             msb;
  logic [PW-2:0]    norm;
  logic [MAN_W-1:0] frac;
  logic             guard, sticky, rnd;
  logic [MAN_W:0]   frac_r;
  logic [EW2-1:0]   exp_f;
  logic [W-1:0]     y_d;
  logic [3:0]       flags_d;

  // The hidden bit is dropped from norm; it is always 1 for non-special operands.
  always_comb begin
    msb    = s2_prod[PW-1];
    norm   = msb ? s2_prod[PW-2:0] : {s2_prod[PW-3:0], 1'b0};
    frac   = norm[PW-2:MAN_W+1];
    guard  = norm[MAN_W];
    sticky = |norm[MAN_W-1:0];
    rnd    = guard && (sticky || frac[0]);
    frac_r = {1'b0, frac} + {{MAN_W{1'b0}}, rnd};
    exp_f  = s2_exp + EW2'(msb) + EW2'(frac_r[MAN_W]);

    y_d     = {s2_sign, exp_f[EXP_W-1:0], frac_r[MAN_W-1:0]};
    flags_d = {3'b000, guard || sticky};

    if (s2_nan) begin
      y_d     = QNAN;
      flags_d = 4'b1000;
    end else if (s2_inf) begin
      y_d     = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_d = 4'b0000;
    end else if (s2_zero) begin
      y_d     = {s2_sign, {(W-1){1'b0}}};
      flags_d = 4'b0000;
    end else if ($signed(exp_f) >= $signed(EMAX_E)) begin
      y_d     = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_d = 4'b0101;
    end else if (exp_f[EW2-1] || (exp_f == '0)) begin
      y_d     = {s2_sign, {(W-1){1'b0}}};
      flags_d = 4'b0011;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      y         <= '0;
      flags     <= 4'b0000;
    end else if (s3_rdy) begin
      out_valid <= s2_v;
      if (s2_v) begin
        y     <= y_d;
        flags <= flags_d;
      end
    end
  end

endmodule
